// File: rtl/reg_dump_controller.sv
// reg_dump_controller: streams the architectural register file out as bytes
// after program finish. Sends HEADER_BYTE, then x0..x(NUM_REGS-1), LSB first.
// It stalls the pipeline and owns the regfile read1 port while a dump runs.
module reg_dump_controller #(
   parameter int unsigned NUM_REGS    = 32,
   parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        dump_sel,
   output logic [4:0]  dump_read_id,
   input  logic [31:0] dump_read_data,
   output logic        stall,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);

   localparam int unsigned IDX_W  = 5;
   localparam int unsigned BYTE_W = 2;
   localparam int unsigned WORD_W = 32;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REGS - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_READ,
      S_SEND,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    reg_idx_q, reg_idx_d;
   logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
   logic [WORD_W-1:0]   word_q, word_d;

   // State and datapath registers; reset aborts any dump in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         reg_idx_q  <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
      end else begin
         state_q    <= state_d;
         reg_idx_q  <= reg_idx_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
      end
   end

   // Next-state logic; outputs are decoded from state and registers only,
   // so tx_ready never reaches tx_valid/tx_data combinationally.
   always_comb begin
      state_d      = state_q;
      reg_idx_d    = reg_idx_q;
      byte_idx_d   = byte_idx_q;
      word_d       = word_q;
      dump_sel     = 1'b0;
      dump_read_id = '0;
      stall        = 1'b0;
      tx_valid     = 1'b0;
      tx_data      = '0;
      busy         = 1'b0;
      done         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_HEADER;
               reg_idx_d = '0;
            end
         end
         S_HEADER: begin
            busy         = 1'b1;
            stall        = 1'b1;
            dump_sel     = 1'b1;
            dump_read_id = reg_idx_q;
            tx_valid     = 1'b1;
            tx_data      = HEADER_BYTE;
            if (tx_ready) begin
               state_d   = S_READ;
               reg_idx_d = '0;
            end
         end
         S_READ: begin
            busy         = 1'b1;
            stall        = 1'b1;
            dump_sel     = 1'b1;
            dump_read_id = reg_idx_q;
            word_d       = dump_read_data;
            byte_idx_d   = '0;
            state_d      = S_SEND;
         end
         S_SEND: begin
            busy         = 1'b1;
            stall        = 1'b1;
            dump_sel     = 1'b1;
            dump_read_id = reg_idx_q;
            tx_valid     = 1'b1;
            tx_data      = 8'(word_q >> {byte_idx_q, 3'b000});
            if (tx_ready) begin
               if (byte_idx_q != LAST_BYTE) begin
                  byte_idx_d = byte_idx_q + BYTE_W'(1);
               end else if (reg_idx_q == LAST_IDX) begin
                  // Checked before the increment, so reg_idx never wraps.
                  state_d = S_DONE;
               end else begin
                  reg_idx_d = reg_idx_q + IDX_W'(1);
                  state_d   = S_READ;
               end
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            stall   = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_dump_controller.sv
// Directed bench for reg_dump_controller: a 32-register instance for the
// main scenarios and a 4-register instance for cycle-exact timing.
module tb_reg_dump_controller;

   logic        clk = 1'b0;
   logic        rst;

   logic        start_a, ready_a;
   logic        sel_a, stall_a, valid_a, busy_a, done_a;
   logic [4:0]  id_a;
   logic [7:0]  data_a;
   logic [31:0] rdata_a;
   logic [31:0] regs_a [32];

   logic        start_b, ready_b;
   logic        sel_b, stall_b, valid_b, busy_b, done_b;
   logic [4:0]  id_b;
   logic [7:0]  data_b;
   logic [31:0] rdata_b;
   logic [31:0] regs_b [32];

   int checks = 0;
   int errors = 0;
   logic [7:0] got [$];
   logic [7:0] exp [$];

   always #5 clk = ~clk;

   assign rdata_a = regs_a[id_a];
   assign rdata_b = regs_b[id_b];

   reg_dump_controller #(.NUM_REGS(32), .HEADER_BYTE(8'hA5)) dut_a (
      .clk(clk), .rst(rst), .start(start_a),
      .dump_sel(sel_a), .dump_read_id(id_a), .dump_read_data(rdata_a),
      .stall(stall_a), .tx_valid(valid_a), .tx_data(data_a), .tx_ready(ready_a),
      .busy(busy_a), .done(done_a)
   );

   reg_dump_controller #(.NUM_REGS(4), .HEADER_BYTE(8'hA5)) dut_b (
      .clk(clk), .rst(rst), .start(start_b),
      .dump_sel(sel_b), .dump_read_id(id_b), .dump_read_data(rdata_b),
      .stall(stall_b), .tx_valid(valid_b), .tx_data(data_b), .tx_ready(ready_b),
      .busy(busy_b), .done(done_b)
   );

   // Reference byte stream: header, then each register LSB first.
   function automatic void build_exp(input logic [31:0] r [32], input int n);
      logic [31:0] w;
      exp.delete();
      exp.push_back(8'hA5);
      for (int i = 0; i < n; i++) begin
         w = r[i];
         for (int b = 0; b < 4; b++) exp.push_back(8'(w >> (8 * b)));
      end
   endfunction

   // Drives one dump on dut_a. inject_at: raise start when that many bytes
   // have been accepted. abort_at: return (holding a valid byte) at that count.
   task automatic run_dump(input int ready_pct, input int inject_at, input int abort_at,
                           output int ndone, output int unstable, output int nostall,
                           output int timeout);
      logic       pend;
      logic [7:0] pdata;
      bit         seen_done;
      bit         injected;
      got.delete();
      ndone = 0; unstable = 0; nostall = 0; timeout = 1;
      pend = 1'b0; pdata = '0; seen_done = 0; injected = 0;
      @(negedge clk); start_a = 1'b1; ready_a = 1'b0;
      @(negedge clk); start_a = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (pend && (valid_a !== 1'b1 || data_a !== pdata)) unstable++;
         if (busy_a && !stall_a) nostall++;
         if (done_a) begin ndone++; seen_done = 1; end
         if (seen_done && !busy_a) begin timeout = 0; break; end
         if (abort_at >= 0 && got.size() == abort_at && valid_a) begin timeout = 0; break; end
         if (inject_at >= 0 && !injected && got.size() == inject_at && valid_a) begin
            start_a = 1'b1; injected = 1;
         end else begin
            start_a = 1'b0;
         end
         ready_a = ($urandom_range(99) < ready_pct);
         if (valid_a && ready_a) got.push_back(data_a);
         pend  = valid_a && !ready_a;
         pdata = data_a;
         @(negedge clk);
      end
      start_a = 1'b0;
      ready_a = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_a = 1'b0; ready_a = 1'b0; start_b = 1'b0; ready_b = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({sel_a, id_a, stall_a, valid_a, data_a, busy_a, done_a} !== 18'd0) begin
         errors++;
         $display("FAIL reset_a outputs got %h want 0", {sel_a, id_a, stall_a, valid_a, data_a, busy_a, done_a});
      end
      checks++;
      if ({sel_b, id_b, stall_b, valid_b, data_b, busy_b, done_b} !== 18'd0) begin
         errors++;
         $display("FAIL reset_b outputs got %h want 0", {sel_b, id_b, stall_b, valid_b, data_b, busy_b, done_b});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_stream(input string name);
      build_exp(regs_a, 32);
      checks++;
      if (got.size() != 129) begin
         errors++;
         $display("FAIL %s byte_count got %0d want 129", name, got.size());
      end
      for (int k = 0; k < 129 && k < got.size(); k++) begin
         checks++;
         if (got[k] !== exp[k]) begin
            errors++;
            $display("FAIL %s byte[%0d] got %h want %h", name, k, got[k], exp[k]);
         end
      end
   endtask

   task automatic test_basic();
      int nd, us, ns, to;
      for (int i = 0; i < 32; i++) regs_a[i] = 32'h1000_0000 + i;
      run_dump(100, -1, -1, nd, us, ns, to);
      checks++; if (to != 0) begin errors++; $display("FAIL basic timeout got %0d want 0", to); end
      checks++; if (nd != 1) begin errors++; $display("FAIL basic done_count got %0d want 1", nd); end
      checks++; if (ns != 0) begin errors++; $display("FAIL basic stall_low got %0d want 0", ns); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic busy_end got %b want 0", busy_a); end
      checks++;
      if (got.size() > 5 && (got[0] !== 8'hA5 || got[4] !== 8'h10 || got[5] !== 8'h01)) begin
         errors++;
         $display("FAIL basic prefix got %h %h %h want a5 10 01", got[0], got[4], got[5]);
      end
      check_stream("basic");
   endtask

   task automatic test_backpressure();
      int nd, us, ns, to;
      run_dump(30, -1, -1, nd, us, ns, to);
      checks++; if (to != 0) begin errors++; $display("FAIL bp timeout got %0d want 0", to); end
      checks++; if (nd != 1) begin errors++; $display("FAIL bp done_count got %0d want 1", nd); end
      checks++; if (us != 0) begin errors++; $display("FAIL bp unstable_cycles got %0d want 0", us); end
      checks++; if (ns != 0) begin errors++; $display("FAIL bp stall_low got %0d want 0", ns); end
      check_stream("bp");
   endtask

   task automatic test_byte_order();
      int nd, us, ns, to;
      logic [31:0] want;
      regs_a[5] = 32'hDEADBEEF;
      run_dump(100, -1, -1, nd, us, ns, to);
      want = 32'hDEADBEEF;
      checks++;
      if (got.size() < 25 || {got[24], got[23], got[22], got[21]} !== want) begin
         errors++;
         $display("FAIL byte_order x5 bytes got size %0d want EF BE AD DE at 21..24", got.size());
      end
      check_stream("byte_order");
      regs_a[5] = 32'h1000_0005;
   endtask

   task automatic test_start_busy();
      int nd, us, ns, to;
      run_dump(100, 30, -1, nd, us, ns, to);
      checks++; if (nd != 1) begin errors++; $display("FAIL start_busy done_count got %0d want 1", nd); end
      check_stream("start_busy");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (busy_a !== 1'b0) begin errors++; $display("FAIL start_busy idle_after busy got %b want 0", busy_a); end
      end
   endtask

   task automatic test_reset_mid();
      int nd, us, ns, to;
      run_dump(100, -1, 51, nd, us, ns, to);
      checks++;
      if (id_a !== 5'd12 || valid_a !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid position got id %0d valid %b want 12 1", id_a, valid_a);
      end
      checks++; if (nd != 0) begin errors++; $display("FAIL rst_mid early_done got %0d want 0", nd); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({sel_a, id_a, stall_a, valid_a, data_a, busy_a, done_a} !== 18'd0) begin
         errors++;
         $display("FAIL rst_mid outputs got %h want 0", {sel_a, id_a, stall_a, valid_a, data_a, busy_a, done_a});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid stays_idle got busy %b done %b want 0 0", busy_a, done_a);
      end
      run_dump(100, -1, -1, nd, us, ns, to);
      checks++; if (nd != 1) begin errors++; $display("FAIL rst_mid redump_done got %0d want 1", nd); end
      check_stream("rst_mid");
   endtask

   // Four-register instance: cycles counted from the HEADER handshake cycle
   // to the DONE cycle inclusive must be 1 + 4*5 + 1 = 22.
   task automatic test_small();
      int hdr_cyc, done_cyc, nd, ns;
      bit fin;
      for (int i = 0; i < 32; i++) regs_b[i] = 32'hC0DE_0000 + 32'(i * 3);
      got.delete();
      hdr_cyc = -1; done_cyc = -1; nd = 0; ns = 0; fin = 0;
      ready_b = 1'b1;
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      checks++;
      if (stall_b !== 1'b1 || sel_b !== 1'b1 || busy_b !== 1'b1) begin
         errors++;
         $display("FAIL small rise got stall %b sel %b busy %b want 1 1 1", stall_b, sel_b, busy_b);
      end
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (busy_b && !stall_b) ns++;
         if (done_b) begin
            nd++; done_cyc = cyc;
            if (sel_b !== 1'b0 || id_b !== 5'd0) ns++;
         end
         if (nd > 0 && !busy_b) begin fin = 1; break; end
         if (valid_b && ready_b) begin
            if (hdr_cyc < 0) hdr_cyc = cyc;
            got.push_back(data_b);
         end
         @(negedge clk);
      end
      checks++; if (!fin) begin errors++; $display("FAIL small timeout got 1 want 0"); end
      checks++; if (nd != 1) begin errors++; $display("FAIL small done_count got %0d want 1", nd); end
      checks++; if (ns != 0) begin errors++; $display("FAIL small stall_or_done_outputs got %0d want 0", ns); end
      checks++;
      if (done_cyc - hdr_cyc + 1 != 22) begin
         errors++;
         $display("FAIL small done_latency got %0d want 22", done_cyc - hdr_cyc + 1);
      end
      build_exp(regs_b, 4);
      checks++;
      if (got.size() != 17) begin errors++; $display("FAIL small byte_count got %0d want 17", got.size()); end
      for (int k = 0; k < 17 && k < got.size(); k++) begin
         checks++;
         if (got[k] !== exp[k]) begin
            errors++;
            $display("FAIL small byte[%0d] got %h want %h", k, got[k], exp[k]);
         end
      end
      ready_b = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin regs_a[i] = '0; regs_b[i] = '0; end
      test_reset();
      test_basic();
      test_backpressure();
      test_byte_order();
      test_start_busy();
      test_reset_mid();
      test_small();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
